// File: rtl/int_to_fp32_conv.sv
// Iterative 32-bit integer (signed/unsigned) to IEEE-754 binary32 converter with valid/ready on both sides.
// Build option: define I2F_ROUND_NEAREST_EN for round-to-nearest-even, otherwise results truncate toward zero.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shifting the magnitude left until bit 31 is set
// ROUND | forming fraction, rounding and packing the result word
// DONE  | result presented, waiting for out_ready
module int_to_fp32_conv #(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [7:0] STEP_E  = 8'(SHIFT_STEP);

    logic [1:0]  r_state;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic [31:0] r_out_data;
    logic        r_out_inexact;

    logic        w_in_sign;
    logic [31:0] w_in_mag;
    logic        w_norm_big;
    logic [31:0] w_norm_mag;
    logic [7:0]  w_norm_exp;
    logic [22:0] w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_inc;
    logic [23:0] w_frac_sum;
    logic [7:0]  w_exp_rnd;

    assign w_in_sign = in_signed & in_data[31];
    assign w_in_mag  = w_in_sign ? (~in_data + 32'd1) : in_data;

    // Wide step only when the whole step window is zero, so the leading one never overshoots bit 31.
    assign w_norm_big = (r_mag[31 -: SHIFT_STEP] == '0);
    assign w_norm_mag = w_norm_big ? (r_mag << SHIFT_STEP) : (r_mag << 1);
    assign w_norm_exp = w_norm_big ? (r_exp - STEP_E) : (r_exp - 8'd1);

    assign w_frac   = r_mag[30:8];
    assign w_guard  = r_mag[7];
    assign w_sticky = |r_mag[6:0];

`ifdef I2F_ROUND_NEAREST_EN
    assign w_round_inc = w_guard & (w_sticky | w_frac[0]);
`else
    assign w_round_inc = 1'b0;
`endif

    // Carry out of the fraction leaves the low 23 bits zero and bumps the exponent.
    assign w_frac_sum = {1'b0, w_frac} + {23'd0, w_round_inc};
    assign w_exp_rnd  = r_exp + {7'd0, w_frac_sum[23]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sign        <= 1'b0;
            r_mag         <= 32'd0;
            r_exp         <= 8'd0;
            r_out_data    <= 32'd0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign <= w_in_sign;
                        r_mag  <= w_in_mag;
                        r_exp  <= 8'd158;
                        if (w_in_mag == 32'd0) begin
                            r_out_data    <= 32'd0;
                            r_out_inexact <= 1'b0;
                            r_state       <= S_DONE;
                        end else if (w_in_mag[31]) begin
                            r_state <= S_ROUND;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    r_mag <= w_norm_mag;
                    r_exp <= w_norm_exp;
                    if (w_norm_mag[31]) begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_out_data    <= {r_sign, w_exp_rnd, w_frac_sum[22:0]};
                    r_out_inexact <= w_guard | w_sticky;
                    r_state       <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_int_to_fp32_conv.sv
// Self-checking bench for int_to_fp32_conv: directed vectors, backpressure, mid-run reset and random operands
// against an arithmetic reference model.
module tb_int_to_fp32_conv;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_inexact;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int_to_fp32_conv #(.SHIFT_STEP(STEP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_signed(in_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_inexact(out_inexact),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer value, scaled to 24 significant bits, rounded by remainder comparison.
    function automatic void model(input logic [31:0] d, input logic s,
                                  output logic [31:0] o, output logic inx, output int lat);
        longint v, m, mant, rem, half;
        int p, sh, pos, k;
        logic sg;
        v   = s ? longint'($signed(d)) : longint'({32'd0, d});
        sg  = (v < 0);
        m   = sg ? -v : v;
        inx = 1'b0;
        if (m == 0) begin
            o   = 32'd0;
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 33; i++) if (m >= (longint'(1) << i)) p = i;
        if (p <= 23) begin
            mant = m << (23 - p);
        end else begin
            sh   = p - 23;
            mant = m >> sh;
            rem  = m - (mant << sh);
            half = longint'(1) << (sh - 1);
            inx  = (rem != 0);
`ifdef I2F_ROUND_NEAREST_EN
            if (rem > half || (rem == half && mant[0])) mant++;
            if (mant == (longint'(1) << 24)) begin
                mant = mant >> 1;
                p++;
            end
`else
            if (half < 0) mant = 0;
`endif
        end
        o = {sg, 8'(127 + p), mant[22:0]};
        pos = p;
        k   = 0;
        while (pos < 31) begin
            pos += (pos + STEP <= 31) ? STEP : 1;
            k++;
        end
        lat = 2 + k;
    endfunction

    task automatic run_op(input logic [31:0] d, input logic s, input int hold, input string tag);
        logic [31:0] eo;
        logic        ei;
        int          el, lat, wn;
        model(d, s, eo, ei, el);
        wn = 0;
        @(negedge clk);
        while (!in_ready && wn < 100) begin
            @(negedge clk);
            wn++;
        end
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " data"}, out_data, eo);
        check({tag, " inexact"}, 32'(out_inexact), 32'(ei));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_data"}, out_data, eo);
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " post_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post_hs_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " post_hs_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset inexact", 32'(out_inexact), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd5, 1'b1, 0, "s5");
        run_op(32'hFFFF_FFF1, 1'b1, 0, "s-15");
        run_op(32'd0, 1'b1, 0, "s0");
        run_op(32'd1, 1'b0, 0, "u1");
        run_op(32'h8000_0000, 1'b1, 0, "s_min");
        run_op(32'h8000_0000, 1'b0, 0, "u_msb");
        run_op(32'hFFFF_FFFF, 1'b0, 0, "u_max");
        run_op(32'h0100_0001, 1'b0, 0, "u_tie");
        run_op(32'h0100_0003, 1'b1, 0, "s_tie_odd");
        run_op(32'h0000_ABCD, 1'b0, 3, "backpressure");

        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 32'd1;
        in_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset in_ready", 32'(in_ready), 32'd1);
        check("midrun_reset out_valid", 32'(out_valid), 32'd0);
        check("midrun_reset out_data", out_data, 32'd0);
        check("midrun_reset inexact", 32'(out_inexact), 32'd0);
        check("midrun_reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'hFFFF_FF00, 1'b1, 0, "after_reset");

        for (int n = 0; n < 30; n++) begin
            rd = $urandom >> $urandom_range(0, 31);
            run_op(rd, 1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
